seq_bit_serializer: RTL and testbench

//  Parallel-to-serial front end for the sequence detectors (Mealy/Moore).

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_bit_serializer.sv | 159 +++++++++++++++
 tb/tb_seq_bit_serializer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector front end and detectors.
package seq_pkg;

    // Default word width for the serializer feeding the detectors.
    localparam int unsigned SEQ_WORD_W = 8;

    // Serializer control state.
    typedef enum logic [0:0] {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// emits them one bit per bit_en strobe on a registered serial line. A single
// holding register lets the next word load on the same edge the current word
// finishes, so consecutive words stream without an idle bit.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = SEQ_WORD_W,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             bit_en_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             word_first_o,
    output logic             busy_o
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    ser_state_t state_q, state_d;

    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_first_q, word_first_d;

    logic cnt_zero;
    logic accept;
    logic load;
    logic shift;
    logic end_word;
    logic first_bit;

    // Event decode shared by the state and datapath next-state logic.
    always_comb begin
        cnt_zero  = (cnt_q == '0);
        // Ready is the inverse of the holding flag, so accept never needs bit_en.
        accept    = s_valid_i & ~hold_valid_q;
        load      = bit_en_i & hold_valid_q &
                    ((state_q == SER_IDLE) | ((state_q == SER_SHIFT) & cnt_zero));
        shift     = bit_en_i & (state_q == SER_SHIFT) & ~cnt_zero;
        end_word  = bit_en_i & (state_q == SER_SHIFT) & cnt_zero & ~hold_valid_q;
        first_bit = MSB_FIRST ? hold_data_q[WIDTH-1] : hold_data_q[0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over every other event.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = SER_IDLE;
        end else if (load) begin
            state_d = SER_SHIFT;
        end else if (end_word) begin
            state_d = SER_IDLE;
        end
    end

    // Datapath next-state: holding register, shifter, counter and serial line.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        word_first_d = word_first_q;

        if (clear_i) begin
            // Flush both the held word and the word in flight; no accept this edge.
            hold_valid_d = 1'b0;
            sreg_d       = '0;
            cnt_d        = '0;
            ser_out_d    = IDLE_BIT;
            ser_valid_d  = 1'b0;
            word_first_d = 1'b0;
        end else begin
            if (load) begin
                sreg_d       = hold_data_q;
                cnt_d        = CntLast;
                hold_valid_d = 1'b0;
                ser_out_d    = first_bit;
                ser_valid_d  = 1'b1;
                word_first_d = 1'b1;
            end else if (shift) begin
                // The bit currently on the line sits at the output end of sreg.
                if (MSB_FIRST) begin
                    sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
                    ser_out_d = sreg_q[WIDTH-2];
                end else begin
                    sreg_d    = {1'b0, sreg_q[WIDTH-1:1]};
                    ser_out_d = sreg_q[1];
                end
                cnt_d        = cnt_q - 1'b1;
                word_first_d = 1'b0;
            end else if (end_word) begin
                ser_out_d    = IDLE_BIT;
                ser_valid_d  = 1'b0;
                word_first_d = 1'b0;
            end

            // A same-edge accept refills the slot that a load just emptied.
            if (accept) begin
                hold_data_d  = s_data_i;
                hold_valid_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            sreg_q       <= '0;
            cnt_q        <= '0;
            ser_out_q    <= IDLE_BIT;
            ser_valid_q  <= 1'b0;
            word_first_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            word_first_q <= word_first_d;
        end
    end

    // Outputs: serial side straight from flops, handshake/busy from flops.
    always_comb begin
        s_ready_o    = ~hold_valid_q;
        busy_o       = (state_q == SER_SHIFT) | hold_valid_q;
        ser_out_o    = ser_out_q;
        ser_valid_o  = ser_valid_q;
        word_first_o = word_first_q;
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first instance (IDLE_BIT=0) and an
// LSB-first instance (IDLE_BIT=1) share stimulus; sel picks which is scored.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int unsigned W = SEQ_WORD_W;

    typedef struct packed {
        logic b;
        logic first;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         bit_en = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         sel = 1'b0;

    logic [1:0] s_ready, ser_out, ser_valid, word_first, busy;
    logic       m_ready, m_out, m_valid, m_first, m_busy, idle_exp;

    int       checks = 0;
    int       errors = 0;
    exp_bit_t exp_q[$];

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_msb (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .bit_en_i    (bit_en),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready[0]),
        .s_data_i    (s_data),
        .ser_out_o   (ser_out[0]),
        .ser_valid_o (ser_valid[0]),
        .word_first_o(word_first[0]),
        .busy_o      (busy[0])
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .bit_en_i    (bit_en),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready[1]),
        .s_data_i    (s_data),
        .ser_out_o   (ser_out[1]),
        .ser_valid_o (ser_valid[1]),
        .word_first_o(word_first[1]),
        .busy_o      (busy[1])
    );

    assign m_ready  = s_ready[sel];
    assign m_out    = ser_out[sel];
    assign m_valid  = ser_valid[sel];
    assign m_first  = word_first[sel];
    assign m_busy   = busy[sel];
    assign idle_exp = sel;

    // Scoreboard monitor: samples on the falling edge, pops one expected bit per
    // strobe edge, checks hold between strobes, pushes bits when a word is accepted.
    initial begin
        logic     en_pend, clr_pend, sel_prev;
        logic     last_out, last_valid, last_first;
        exp_bit_t e;
        int       idx;
        en_pend = 1'b0; clr_pend = 1'b0; sel_prev = 1'b0;
        last_out = 1'b0; last_valid = 1'b0; last_first = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                en_pend  = 1'b0;
                clr_pend = 1'b0;
            end else begin
                if (clr_pend) begin
                    checks++;
                    if (m_valid !== 1'b0 || m_out !== idle_exp || m_first !== 1'b0 ||
                        m_ready !== 1'b1 || m_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL clear_state got v=%b o=%b f=%b r=%b b=%b required 0 %b 0 1 0",
                                 m_valid, m_out, m_first, m_ready, m_busy, idle_exp);
                    end
                end else if (en_pend) begin
                    checks++;
                    if (m_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_bit got ser_out=%b required no valid bit", m_out);
                        end else begin
                            e = exp_q.pop_front();
                            if (m_out !== e.b || m_first !== e.first) begin
                                errors++;
                                $display("FAIL serial_bit got out=%b first=%b required out=%b first=%b",
                                         m_out, m_first, e.b, e.first);
                            end
                        end
                    end else if (m_out !== idle_exp || m_first !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_line got out=%b first=%b required out=%b first=0",
                                 m_out, m_first, idle_exp);
                    end
                end else if (sel == sel_prev) begin
                    checks++;
                    if (m_out !== last_out || m_valid !== last_valid || m_first !== last_first) begin
                        errors++;
                        $display("FAIL hold_no_strobe got o=%b v=%b f=%b required o=%b v=%b f=%b",
                                 m_out, m_valid, m_first, last_out, last_valid, last_first);
                    end
                end
                // Stimulus that the coming rising edge will see.
                if (clear) begin
                    exp_q.delete();
                end else if (s_valid && m_ready) begin
                    for (int i = 0; i < int'(W); i++) begin
                        idx     = sel ? i : int'(W) - 1 - i;
                        e.b     = s_data[idx];
                        e.first = (i == 0);
                        exp_q.push_back(e);
                    end
                end
                en_pend  = bit_en;
                clr_pend = clear;
            end
            last_out   = m_out;
            last_valid = m_valid;
            last_first = m_first;
            sel_prev   = sel;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted; waits counts stalled cycles.
    task automatic send_word(input logic [W-1:0] w, output int waits);
        logic rdy;
        s_valid = 1'b1;
        s_data  = w;
        waits   = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            rdy = m_ready;
            tick();
            if (rdy) begin
                s_valid = 1'b0;
                return;
            end
            waits++;
        end
        s_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout got no accept of %h required accept within 100 cycles", w);
    endtask

    task automatic drain();
        bit_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!m_busy && !m_valid) break;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain got pending=%0d busy=%b required 0 0", exp_q.size(), m_busy);
        end
        tick();
    endtask

    task automatic test_reset();
        int waits;
        int nvalid;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (ser_valid[0] !== 1'b0 || ser_out[0] !== 1'b0 || s_ready[0] !== 1'b1 ||
            busy[0] !== 1'b0 || word_first[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b o=%b r=%b b=%b f=%b required 0 0 1 0 0",
                     ser_valid[0], ser_out[0], s_ready[0], busy[0], word_first[0]);
        end
        bit_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        // Async reset in the middle of a word.
        send_word(8'hC3, waits);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_premise got ser_valid=%b required 1", m_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_out !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got v=%b o=%b r=%b b=%b required 0 0 1 0",
                     m_valid, m_out, m_ready, m_busy);
        end
        tick();
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL reset_no_tail got %0d valid cycles required 0", nvalid);
        end
        tick();
    endtask

    task automatic test_single_word();
        int         waits;
        logic [9:0] vv, bv, fv, ov;
        send_word(8'hB4, waits);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vv[i] = m_valid;
            bv[i] = m_busy;
            fv[i] = m_first;
            ov[i] = m_out;
        end
        checks++;
        if (vv !== 10'h1FE) begin
            errors++;
            $display("FAIL single_valid got %b required %b", vv, 10'h1FE);
        end
        checks++;
        if (fv !== 10'h002) begin
            errors++;
            $display("FAIL single_first got %b required %b", fv, 10'h002);
        end
        checks++;
        if (ov !== 10'h05A) begin
            errors++;
            $display("FAIL single_bits got %b required %b", ov, 10'h05A);
        end
        checks++;
        if (bv !== 10'h1FF) begin
            errors++;
            $display("FAIL single_busy got %b required %b", bv, 10'h1FF);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int          waits;
        logic [19:0] vv, rv;
        fork
            begin
                send_word(8'hFF, waits);
                send_word(8'h00, waits);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    vv[i] = m_valid;
                    rv[i] = m_ready;
                end
            end
        join
        checks++;
        if (vv !== 20'h3FFFC) begin
            errors++;
            $display("FAIL b2b_valid got %h required %h", vv, 20'h3FFFC);
        end
        checks++;
        if (rv !== 20'hFFC05) begin
            errors++;
            $display("FAIL b2b_ready got %h required %h", rv, 20'hFFC05);
        end
        drain();
    endtask

    task automatic test_slow_strobe();
        int waits;
        int nvalid;
        sel    = 1'b1;
        nvalid = 0;
        tick();
        fork
            send_word(8'h01, waits);
            begin
                for (int i = 0; i < 40; i++) begin
                    bit_en = (i % 3 == 0);
                    @(negedge clk);
                    if (m_valid) nvalid++;
                    tick();
                end
            end
        join
        bit_en = 1'b1;
        checks++;
        if (nvalid != 24) begin
            errors++;
            $display("FAIL slow_valid_cycles got %0d required 24", nvalid);
        end
        drain();
        sel = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int waits;
        int nvalid;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();              // A5 accepted
        s_data = 8'h3C;
        tick();              // A5 loaded, first bit
        tick();              // 3C accepted, second bit
        s_valid = 1'b0;
        tick();              // third bit on the line
        checks++;
        if (m_ready !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_premise got r=%b v=%b required 0 1", m_ready, m_valid);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush got v=%b r=%b b=%b required 0 1 0", m_valid, m_ready, m_busy);
        end
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL clear_dropped got %0d valid cycles required 0", nvalid);
        end
        tick();
        send_word(8'h81, waits);
        drain();
    endtask

    task automatic test_stall_order();
        int          waits;
        logic [W-1:0] words [4];
        words[0] = 8'h5A;
        words[1] = 8'hC3;
        words[2] = 8'h0F;
        words[3] = 8'h96;
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], waits);
            if (i >= 2) begin
                checks++;
                if (waits != 7) begin
                    errors++;
                    $display("FAIL stall_cycles word%0d got %0d required 7", i, waits);
                end
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_slow_strobe();
        test_clear();
        test_stall_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
